// File: rtl/vga_text_line.sv
// Single-line text renderer: character buffer, font ROM fetch and a two-stage
// pixel pipeline producing registered RGB with syncs delayed to match.
module vga_text_line #(
  parameter int         NUM_CHARS  = 8,
  parameter int         CODE_W     = 4,
  parameter int         X0         = 8,
  parameter int         Y0         = 300,
  parameter int         SCALE_LOG2 = 0,
  parameter int         BLINK_LOG2 = 5,
  parameter logic [2:0] FG_RGB     = 3'b111,
  parameter logic [2:0] BG_RGB     = 3'b000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_ce,
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  input  logic              valid,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              newframe,
  input  logic              wr_en,
  input  logic [5:0]        wr_addr,
  input  logic [CODE_W:0]   wr_data,
  output logic [CODE_W-1:0] font_char,
  output logic [2:0]        font_row,
  input  logic [7:0]        font_bits,
  output logic              R,
  output logic              G,
  output logic              B,
  output logic              hsync,
  output logic              vsync
);

  localparam int                IDX_W    = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1;
  localparam int                GLYPH_PX = 8 << SCALE_LOG2;
  localparam logic [11:0]       WIN_W    = 12'(NUM_CHARS * GLYPH_PX);
  localparam logic [9:0]        WIN_H    = 10'(GLYPH_PX);
  localparam logic [CODE_W-1:0] BLANK    = '1;

  logic [CODE_W:0] slot_q [NUM_CHARS];

  // Window geometry. The x>=X0 / y>=Y0 terms keep the 10-bit subtraction
  // from wrapping pixels left of or above the line into the window.
  logic [9:0]       dx, dy, col;
  logic             in_win_d, rd_ok, wr_ok;
  logic [IDX_W-1:0] rd_idx;
  logic [CODE_W:0]  slot_rd;
  logic [2:0]       row_d;

  assign dx       = x - 10'(X0);
  assign dy       = y - 10'(Y0);
  assign col      = dx >> SCALE_LOG2;
  assign row_d    = 3'(dy >> SCALE_LOG2);
  assign in_win_d = valid && (x >= 10'(X0)) && ({2'b00, dx} < WIN_W)
                          && (y >= 10'(Y0)) && (dy < WIN_H);
  assign rd_ok    = (col[9:3] < 7'(NUM_CHARS));
  assign rd_idx   = col[3 +: IDX_W];
  assign slot_rd  = rd_ok ? slot_q[rd_idx] : {1'b0, BLANK};
  assign wr_ok    = ({1'b0, wr_addr} < 7'(NUM_CHARS));

  // Buffer writes are not gated by pix_ce; a same-edge read sees the old slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CHARS; i++) slot_q[i] <= {1'b0, BLANK};
    end else if (wr_en && wr_ok) begin
      slot_q[wr_addr[IDX_W-1:0]] <= wr_data;
    end
  end

  logic [CODE_W-1:0] font_char_q, code2_q;
  logic [2:0]        font_row_q, bit1_q, bit2_q, rgb_q, rgb_d;
  logic              blink1_q, win1_q, hs1_q, vs1_q;
  logic              blink2_q, win2_q, hs2_q, vs2_q;
  logic              hsync_q, vsync_q, on_d;
  logic [BLINK_LOG2:0] frame_q, frame_d;

  assign frame_d = frame_q + {{BLINK_LOG2{1'b0}}, 1'b1};

  // font_bits is the ROM's answer to the stage-1 request, so it lines up with stage 2.
  always_comb begin
    on_d  = win2_q && font_bits[~bit2_q] && !(blink2_q && frame_q[BLINK_LOG2])
                   && (code2_q != BLANK);
    rgb_d = 3'b000;
    if (win2_q) rgb_d = on_d ? FG_RGB : BG_RGB;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      font_char_q <= '0;
      font_row_q  <= '0;
      blink1_q    <= 1'b0;
      bit1_q      <= '0;
      win1_q      <= 1'b0;
      hs1_q       <= 1'b0;
      vs1_q       <= 1'b0;
      code2_q     <= '0;
      blink2_q    <= 1'b0;
      bit2_q      <= '0;
      win2_q      <= 1'b0;
      hs2_q       <= 1'b0;
      vs2_q       <= 1'b0;
      rgb_q       <= '0;
      hsync_q     <= 1'b0;
      vsync_q     <= 1'b0;
      frame_q     <= '0;
    end else if (pix_ce) begin
      font_char_q <= slot_rd[CODE_W-1:0];
      font_row_q  <= row_d;
      blink1_q    <= slot_rd[CODE_W];
      bit1_q      <= col[2:0];
      win1_q      <= in_win_d;
      hs1_q       <= hsync_in;
      vs1_q       <= vsync_in;
      code2_q     <= font_char_q;
      blink2_q    <= blink1_q;
      bit2_q      <= bit1_q;
      win2_q      <= win1_q;
      hs2_q       <= hs1_q;
      vs2_q       <= vs1_q;
      rgb_q       <= rgb_d;
      hsync_q     <= hs2_q;
      vsync_q     <= vs2_q;
      if (newframe) frame_q <= frame_d;
    end
  end

  assign font_char = font_char_q;
  assign font_row  = font_row_q;
  assign R         = rgb_q[2];
  assign G         = rgb_q[1];
  assign B         = rgb_q[0];
  assign hsync     = hsync_q;
  assign vsync     = vsync_q;

endmodule

// File: tb/tb_vga_text_line.sv
// Bench for vga_text_line: a default instance and a 2x-scaled instance with
// distinct colours share one stimulus stream; each has its own font ROM model.
module tb_vga_text_line;

  logic       clk = 1'b0, rst = 1'b1, pix_ce = 1'b0;
  logic [9:0] x = '0, y = '0;
  logic       valid = 1'b0, hsync_in = 1'b0, vsync_in = 1'b0, newframe = 1'b0;
  logic       wr_en = 1'b0;
  logic [5:0] wr_addr = '0;
  logic [4:0] wr_data = '0;

  logic [3:0] fc_d, fc_s;
  logic [2:0] fr_d, fr_s;
  logic [7:0] fb_d = '0, fb_s = '0;
  logic       r_d, g_d, b_d, hs_d, vs_d;
  logic       r_s, g_s, b_s, hs_s, vs_s;

  vga_text_line dut (
    .clk(clk), .rst(rst), .pix_ce(pix_ce), .x(x), .y(y), .valid(valid),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .newframe(newframe),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .font_char(fc_d), .font_row(fr_d), .font_bits(fb_d),
    .R(r_d), .G(g_d), .B(b_d), .hsync(hs_d), .vsync(vs_d)
  );

  vga_text_line #(.SCALE_LOG2(1), .FG_RGB(3'b110), .BG_RGB(3'b001)) dut_s (
    .clk(clk), .rst(rst), .pix_ce(pix_ce), .x(x), .y(y), .valid(valid),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .newframe(newframe),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .font_char(fc_s), .font_row(fr_s), .font_bits(fb_s),
    .R(r_s), .G(g_s), .B(b_s), .hsync(hs_s), .vsync(vs_s)
  );

  always #5 clk = ~clk;

  // Bench font: code 11 is an 'F', every other code a distinct non-zero pattern.
  function automatic logic [7:0] font(input logic [3:0] c, input logic [2:0] r);
    if (c == 4'd11) begin
      case (r)
        3'd0:                font = 8'hFE;
        3'd3:                font = 8'hFC;
        3'd7:                font = 8'h00;
        default:             font = 8'hC0;
      endcase
    end else begin
      font = {c, 1'b1, r};
    end
  endfunction

  always @(posedge clk) begin
    if (pix_ce) begin
      fb_d <= font(fc_d, fr_d);
      fb_s <= font(fc_s, fr_s);
    end
  end

  // Scoreboard state
  logic [9:0] exp_q[$];
  logic [4:0] m_slot [8];
  logic [5:0] m_frame;
  int         checks = 0, errors = 0;
  string      tname = "init";

  function automatic logic [2:0] model_rgb(input logic [9:0] px, input logic [9:0] py,
                                           input logic v, input int sl,
                                           input logic [2:0] fg, input logic [2:0] bg);
    int w, h, col, idx, b, r;
    logic [4:0] s;
    logic [7:0] fb;
    w = 64 << sl;
    h = 8 << sl;
    if (!v || int'(px) < 8 || int'(px) >= 8 + w || int'(py) < 300 || int'(py) >= 300 + h)
      return 3'b000;
    col = (int'(px) - 8) >> sl;
    idx = col / 8;
    b   = col % 8;
    r   = ((int'(py) - 300) >> sl) % 8;
    s   = m_slot[idx];
    fb  = font(s[3:0], 3'(r));
    if (fb[7-b] && !(s[4] && m_frame[5]) && s[3:0] != 4'hF) return fg;
    return bg;
  endfunction

  function automatic logic [9:0] model_e(input logic [9:0] px, input logic [9:0] py,
                                         input logic v, input logic hs, input logic vs);
    return {model_rgb(px, py, v, 0, 3'b111, 3'b000), hs, vs,
            model_rgb(px, py, v, 1, 3'b110, 3'b001), hs, vs};
  endfunction

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, got, exp);
    end
  endtask

  // One pixel: pix_ce edge, then an idle edge, then compare against the
  // expectation queued two pixels earlier. Call at a negedge.
  task automatic step(input logic [9:0] px, input logic [9:0] py, input logic v,
                      input logic hs, input logic vs, input logic nf,
                      input logic we, input logic [5:0] wa, input logic [4:0] wd,
                      input logic [9:0] e);
    logic [9:0] ev;
    x = px; y = py; valid = v; hsync_in = hs; vsync_in = vs; newframe = nf;
    wr_en = we; wr_addr = wa; wr_data = wd; pix_ce = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    pix_ce = 1'b0; wr_en = 1'b0; newframe = 1'b0;
    @(negedge clk);
    ev = exp_q.pop_front();
    chk(tname, {6'b0, r_d, g_d, b_d, hs_d, vs_d, r_s, g_s, b_s, hs_s, vs_s}, {6'b0, ev});
  endtask

  task automatic pix(input logic [9:0] px, input logic [9:0] py, input logic v);
    logic hs, vs;
    hs = 1'($urandom_range(0, 1));
    vs = 1'($urandom_range(0, 1));
    step(px, py, v, hs, vs, 1'b0, 1'b0, 6'd0, 5'd0, model_e(px, py, v, hs, vs));
  endtask

  task automatic frame_pulse();
    step(10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0, 5'd0, 10'd0);
    m_frame = m_frame + 6'd1;
  endtask

  task automatic wr(input logic [5:0] a, input logic [4:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    if (a < 6'd8) m_slot[a[2:0]] = d;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_slot[i] = 5'h0F;
    m_frame = '0;
    exp_q.delete();
    exp_q.push_back(10'd0);
    exp_q.push_back(10'd0);
  endtask

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic       v;
    logic [2:0] rd;
    logic [2:0] rs;
  } vec_t;
  vec_t tbl [18];

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Slot0 holds 'F', all other slots blank; default FG 111/BG 000, scaled FG 110/BG 001.
    tbl[0]  = '{10'd7,   10'd300, 1'b1, 3'b000, 3'b000};
    tbl[1]  = '{10'd8,   10'd300, 1'b1, 3'b111, 3'b110};
    tbl[2]  = '{10'd15,  10'd300, 1'b1, 3'b000, 3'b110};
    tbl[3]  = '{10'd10,  10'd303, 1'b1, 3'b111, 3'b110};
    tbl[4]  = '{10'd14,  10'd303, 1'b1, 3'b000, 3'b001};
    tbl[5]  = '{10'd9,   10'd301, 1'b1, 3'b111, 3'b110};
    tbl[6]  = '{10'd10,  10'd301, 1'b1, 3'b000, 3'b110};
    tbl[7]  = '{10'd8,   10'd307, 1'b1, 3'b000, 3'b110};
    tbl[8]  = '{10'd8,   10'd308, 1'b1, 3'b000, 3'b110};
    tbl[9]  = '{10'd72,  10'd300, 1'b1, 3'b000, 3'b001};
    tbl[10] = '{10'd71,  10'd300, 1'b1, 3'b000, 3'b001};
    tbl[11] = '{10'd8,   10'd300, 1'b0, 3'b000, 3'b000};
    tbl[12] = '{10'd135, 10'd315, 1'b1, 3'b000, 3'b001};
    tbl[13] = '{10'd136, 10'd300, 1'b1, 3'b000, 3'b000};
    tbl[14] = '{10'd22,  10'd314, 1'b1, 3'b000, 3'b001};
    tbl[15] = '{10'd23,  10'd300, 1'b1, 3'b000, 3'b001};
    tbl[16] = '{10'd8,   10'd299, 1'b1, 3'b000, 3'b000};
    tbl[17] = '{10'd9,   10'd316, 1'b1, 3'b000, 3'b000};

    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_out", {6'b0, r_d, g_d, b_d, hs_d, vs_d, r_s, g_s, b_s, hs_s, vs_s}, 16'd0);
    chk("reset_font", {2'b0, fc_d, fr_d, fc_s, fr_s}, 16'd0);
    rst = 1'b0;
    @(negedge clk);

    tname = "blank_scan";
    for (int yy = 296; yy < 320; yy++)
      for (int xx = 0; xx < 144; xx++) pix(10'(xx), 10'(yy), 1'b1);

    tname = "glyph_scan";
    wr(6'd0, {1'b0, 4'd11});
    for (int yy = 300; yy < 316; yy++)
      for (int xx = 0; xx < 141; xx++) pix(10'(xx), 10'(yy), 1'b1);

    tname = "table";
    for (int i = 0; i < 18; i++) begin
      logic hs, vs;
      hs = i[0];
      vs = i[1];
      step(tbl[i].x, tbl[i].y, tbl[i].v, hs, vs, 1'b0, 1'b0, 6'd0, 5'd0,
           {tbl[i].rd, hs, vs, tbl[i].rs, hs, vs});
    end

    tname = "oob_write";
    wr(6'd8, {1'b0, 4'd5});
    wr(6'd63, {1'b1, 4'd5});
    for (int yy = 300; yy < 302; yy++)
      for (int xx = 0; xx < 72; xx++) pix(10'(xx), 10'(yy), 1'b1);

    // Write slot3 on the same edge that stage 1 reads it for x=32.
    tname = "same_edge";
    pix(10'd31, 10'd300, 1'b1);
    step(10'd32, 10'd300, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 6'd3, {1'b0, 4'd11},
         {3'b000, 2'b00, 3'b001, 2'b00});
    m_slot[3] = {1'b0, 4'd11};
    step(10'd33, 10'd300, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 5'd0,
         {3'b111, 2'b00, 3'b001, 2'b00});
    for (int xx = 32; xx < 41; xx++) pix(10'(xx), 10'(300), 1'b1);

    tname = "blink";
    wr(6'd2, {1'b1, 4'd14});
    for (int f = 0; f <= 64; f++) begin
      logic [2:0] ed, es;
      ed = ((f % 64) < 32) ? 3'b111 : 3'b000;
      es = ((f % 64) < 32) ? 3'b110 : 3'b001;
      step(10'd24, 10'd300, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 5'd0, {ed, 2'b00, 3'b001, 2'b00});
      step(10'd40, 10'd300, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 5'd0, {3'b000, 2'b00, es, 2'b00});
      pix(10'd0, 10'd0, 1'b0);
      pix(10'd0, 10'd0, 1'b0);
      frame_pulse();
    end
    for (int f = 0; f < 31; f++) frame_pulse();
    pix(10'd0, 10'd0, 1'b0);
    step(10'd24, 10'd300, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 5'd0, {3'b000, 2'b00, 3'b001, 2'b00});

    tname = "mid_reset_pre";
    for (int i = 0; i < 3; i++)
      step(10'd8, 10'd300, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0, 5'd0, {3'b111, 2'b11, 3'b110, 2'b11});
    rst = 1'b1;
    #1;
    chk("mid_reset_out", {6'b0, r_d, g_d, b_d, hs_d, vs_d, r_s, g_s, b_s, hs_s, vs_s}, 16'd0);
    chk("mid_reset_font", {2'b0, fc_d, fr_d, fc_s, fr_s}, 16'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    tname = "after_reset";
    for (int xx = 8; xx < 16; xx++) pix(10'(xx), 10'(300), 1'b1);
    wr(6'd2, {1'b1, 4'd14});
    step(10'd24, 10'd300, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 5'd0, {3'b111, 2'b01, 3'b001, 2'b01});
    step(10'd40, 10'd300, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 5'd0, {3'b000, 2'b10, 3'b110, 2'b10});
    pix(10'd0, 10'd0, 1'b0);
    pix(10'd0, 10'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_text_line.md
Name: vga_text_line

Overview:
- Parametrised single-line text renderer for the VGA path.
- Consumes the vga timing block's pixel coordinates and syncs, holds a writable character buffer, fetches glyph rows from the external chars font ROM, and produces registered RGB with delayed syncs.
- Generalises the fixed 8-character monochrome line: adds a runtime-writable buffer, character count, origin, integer scale, per-character blink and fg/bg colours.

Parameters:
- NUM_CHARS, 8, characters in the line (1..64).
- CODE_W, 4, character code width; all-ones code is the blank glyph.
- X0, 8, left pixel column of the line.
- Y0, 300, top pixel row of the line.
- SCALE_LOG2, 0, glyph magnification 2^SCALE_LOG2 (0..2).
- BLINK_LOG2, 5, blink half-period in frames (2^BLINK_LOG2).
- FG_RGB, 3'b111, {R,G,B} for set glyph bits.
- BG_RGB, 3'b000, {R,G,B} for clear bits inside the line window.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- pix_ce  in  1  pixel clock enable (one clk per VGA pixel)
- x  in  10  current pixel column
- y  in  10  current pixel row
- valid  in  1  visible-area flag
- hsync_in  in  1  hsync from timing block
- vsync_in  in  1  vsync from timing block
- newframe  in  1  one-pixel frame-start pulse
- wr_en  in  1  buffer write strobe
- wr_addr  in  6  character slot
- wr_data  in  CODE_W+1  {blink, code}
- font_char  out  CODE_W  glyph code to font ROM
- font_row  out  3  glyph row to font ROM
- font_bits  in  8  font ROM row; MSB is the leftmost pixel; registered in ROM on pix_ce, valid one pix_ce after request
- R, G, B  out  1 each  pixel colour
- hsync  out  1  hsync_in delayed to match RGB
- vsync  out  1  vsync_in delayed to match RGB

Behaviour:
Reset:
- Asynchronous reset, active-high.
- R, G, B, hsync, vsync, font_char, font_row and all pipeline registers clear to 0.
- Frame counter clears to 0.
- Every buffer slot resets to {0, all-ones} (blank, no blink).

Buffer writes:
- On any clk edge, independent of pix_ce: when wr_en=1 and wr_addr<NUM_CHARS, slot[wr_addr] <= wr_data.
- Writes with wr_addr>=NUM_CHARS are ignored.
- A write and a stage-1 read of the same slot on the same edge: the read returns the old value.

Window and addressing (combinational on the inputs):
- W = NUM_CHARS*8<<SCALE_LOG2.
- in_win = valid && X0<=x<X0+W && Y0<=y<Y0+(8<<SCALE_LOG2).
- col = (x-X0)>>SCALE_LOG2; idx = col[8:3]; bit = col[2:0].
- row = ((y-Y0)>>SCALE_LOG2)[2:0].
- All arithmetic is 10-bit unsigned; x<X0 is outside the window (no wrap).

Pipeline (advances only when pix_ce=1; all registers hold otherwise):
- Stage 1 registers code=slot[idx].code, blink=slot[idx].blink, bit, in_win, hsync_in, vsync_in.
- font_char = stage-1 code; font_row = stage-1 row. Both are registered outputs.
- Stage 2 registers bit, in_win, blink, syncs from stage 1. font_bits is now valid for that pixel.
- Output register:
  - on = in_win2 && font_bits[7-bit2] && !(blink2 && phase) && code2 != all-ones.
  - {R,G,B} <= !in_win2 ? 3'b000 : (on ? FG_RGB : BG_RGB).
  - hsync, vsync <= stage-2 syncs.
- Latency: inputs sampled at pix_ce edge n appear on RGB/syncs at pix_ce edge n+2. Syncs and RGB remain aligned.

Blink:
- Frame counter (BLINK_LOG2+1 bits) increments when pix_ce && newframe; it wraps.
- phase = counter MSB.
- Blink-flagged characters render as BG_RGB during phase=1.

Reset mid-frame: outputs drop to 0 immediately; the pipeline refills within 2 pix_ce.

Test Plan:
- Defaults; reset, then scan a full frame -> every buffer slot reads blank, all RGB=0, hsync/vsync equal the inputs delayed 2 pix_ce.
- Write slot0={0,code 11 ('F')}; scan y=300..307, x=8..15 -> RGB=111 exactly where the font row MSB-first bits are 1, 000 elsewhere, 2-pix_ce latency.
- x=7 and x=72 with y=300 -> both outside the window, RGB=000. x=71 -> in window, BG or FG.
- SCALE_LOG2=1: write slot0 'F' -> each glyph bit spans 2 columns and 2 rows; the window is x 8..135, y 300..315.
- Write slot2={1,code 14}; run 64 frames -> glyph visible frames 0-31, background frames 32-63.
- wr_en with wr_addr=8 (NUM_CHARS=8) -> no slot changes. Write slot3 on the same clk as its stage-1 read -> the old glyph is displayed for that pixel, the new glyph from the next pixel of slot3.
